data_mem_wait_ctrl: RTL

//  Multi-cycle data memory for the MEM stage of the 5-stage MIPS pipeline.
//  - Accepts one load/store request per access.
//  - Inserts WAIT_STATES idle cycles before it performs the access.
//  - Asserts freeze to hold PC, IF/ID, ID/EXE and EXE/MEM until the access completes.
//  - Feeds load data to the MEM/WB register.

---
 rtl/data_mem_wait_ctrl.sv | 125 ++++++++++++
 1 files changed

// File: rtl/data_mem_wait_ctrl.sv
// Multi-cycle word-addressed data memory for the MEM stage: accepts a load/store,
// idles WAIT_STATES cycles, performs the access, then pulses ready for one cycle.
module data_mem_wait_ctrl #(
    parameter int WORDS       = 64,
    parameter int BASE_ADDR   = 1024,
    parameter int WAIT_STATES = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        mem_r_en,
    input  logic        mem_w_en,
    input  logic [31:0] alu_result,
    input  logic [31:0] st_val,
    output logic [31:0] mem_rd_data,
    output logic        ready,
    output logic        freeze,
    output logic        addr_err
);

    localparam int IW = (WORDS > 1) ? $clog2(WORDS) : 1;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_WAIT = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t state, state_nxt;

    logic          req;
    logic [31:0]   offset;
    logic          in_range;
    logic          bad_req;
    logic          accept;
    logic          access;
    logic          unused_bits;

    logic          op_store;
    logic [IW-1:0] idx;
    logic [31:0]   st_q;
    logic          valid_q;
    logic [3:0]    cnt;

    logic [31:0]   mem [WORDS];

    assign req         = mem_r_en | mem_w_en;
    assign offset      = alu_result - 32'(BASE_ADDR);
    assign in_range    = (alu_result >= 32'(BASE_ADDR)) && (offset[31:2] < 30'(WORDS));
    assign bad_req     = ~in_range | (mem_r_en & mem_w_en);
    assign unused_bits = ^offset[1:0];

    assign accept = (state == S_IDLE) && req;
    // The access happens in the last WAIT cycle, only if the request is still held.
    assign access = (state == S_WAIT) && req && (cnt == 4'd0);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE: begin
                if (req) state_nxt = S_WAIT;
            end
            S_WAIT: begin
                if (!req) begin
                    state_nxt = S_IDLE;
                end else if (cnt == 4'd0) begin
                    state_nxt = S_DONE;
                end
            end
            S_DONE: begin
                state_nxt = S_IDLE;
            end
            default: begin
                state_nxt = S_IDLE;
            end
        endcase
    end

    always_comb begin
        ready  = (state == S_DONE);
        freeze = req & ~ready;
    end

    // Request context is captured once on acceptance; later input changes are ignored.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt         <= 4'd0;
            mem_rd_data <= 32'd0;
            addr_err    <= 1'b0;
            op_store    <= 1'b0;
            idx         <= '0;
            st_q        <= 32'd0;
            valid_q     <= 1'b0;
        end else begin
            if (accept) begin
                op_store <= mem_w_en;
                idx      <= offset[IW+1:2];
                st_q     <= st_val;
                valid_q  <= in_range;
                cnt      <= 4'(WAIT_STATES);
                if (bad_req) addr_err <= 1'b1;
            end else if ((state == S_WAIT) && req && (cnt != 4'd0)) begin
                cnt <= cnt - 4'd1;
            end
            if (access && !op_store) begin
                mem_rd_data <= valid_q ? mem[idx] : 32'd0;
            end
        end
    end

    // The array has no reset; a reset mid-WAIT drops state first, so no write occurs.
    always_ff @(posedge clk) begin
        if (access && op_store && valid_q && !rst) begin
            mem[idx] <= st_q;
        end
    end

endmodule
